// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=3, rate-1/2 hard-decision Viterbi datapath.
package viterbi_pkg;
  localparam int K       = 3;
  localparam int NSTATES = 4;
  localparam int PM_W    = 8;

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_RUN   = 1'b1
  } acs_state_e;

  // reg_bits = {u, b1, b0}; returns {c1, c0}
  function automatic logic [1:0] code_bits(input logic [K-1:0] reg_bits);
    return {^(reg_bits & G1), ^(reg_bits & G0)};
  endfunction
endpackage

// File: rtl/viterbi_acs_if.sv
// Symbol input and ACS result bundle of viterbi_acs.
// st is a valid-only strobe: a symbol on r0/r1 is taken on every rising edge
// with st=1 and there is no backpressure; out_st marks each updated result.
interface viterbi_acs_if;
  import viterbi_pkg::*;

  logic            st;
  logic            r0;
  logic            r1;
  logic            out_st;
  logic            out_last;
  logic [PM_W-1:0] pm0;
  logic [PM_W-1:0] pm1;
  logic [PM_W-1:0] pm2;
  logic [PM_W-1:0] pm3;
  logic [3:0]      dec;
  logic [1:0]      best;
  acs_state_e      fsm_state;

  modport slave (
    input  st, r0, r1,
    output out_st, out_last, pm0, pm1, pm2, pm3, dec, best, fsm_state
  );

  modport master (
    output st, r0, r1,
    input  out_st, out_last, pm0, pm1, pm2, pm3, dec, best, fsm_state
  );
endinterface

// File: rtl/viterbi_acs_butterfly.sv
// Branch metric, compare and select for one destination state DST = {u, b1}.
module viterbi_acs_butterfly
  import viterbi_pkg::*;
#(
  parameter int unsigned DST = 0
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic            r0,
  input  logic            r1,
  output logic [PM_W:0]   pm_new,
  output logic            dec
);
  localparam logic [1:0] DST_BITS = 2'(DST);
  localparam logic       U        = DST_BITS[1];
  localparam logic       B1       = DST_BITS[0];

  logic [1:0]    cb_a, cb_b;
  logic [1:0]    bm_a, bm_b;
  logic [PM_W:0] cand_a, cand_b;

  assign cb_a = code_bits({U, B1, 1'b0});
  assign cb_b = code_bits({U, B1, 1'b1});

  assign bm_a = {1'b0, r0 ^ cb_a[0]} + {1'b0, r1 ^ cb_a[1]};
  assign bm_b = {1'b0, r0 ^ cb_b[0]} + {1'b0, r1 ^ cb_b[1]};

  assign cand_a = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
  assign cand_b = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};

  // Ties keep the even predecessor
  assign dec    = (cand_b < cand_a);
  assign pm_new = dec ? cand_b : cand_a;
endmodule

// File: rtl/viterbi_acs.sv
// Four-state add-compare-select stage with metric normalisation and frame control.
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int INIT_PM   = 16,
  parameter int FRAME_LEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  viterbi_acs_if.slave  bus
);
  localparam logic [PM_W-1:0] INIT_V   = PM_W'(INIT_PM);
  localparam logic [7:0]      LAST_CNT = 8'(FRAME_LEN - 1);

  logic [PM_W-1:0]    ipm   [NSTATES];
  logic [PM_W-1:0]    pm_q  [NSTATES];
  logic [PM_W:0]      cand  [NSTATES];
  logic [PM_W-1:0]    norm  [NSTATES];
  logic [PM_W:0]      new_min;
  logic [NSTATES-1:0] dec_c, dec_q;
  logic [1:0]         best_c, best_q;
  logic [7:0]         cnt;
  logic               last_sym;
  logic               out_st_q, out_last_q;
  acs_state_e         state, state_nx;

  for (genvar g = 0; g < NSTATES; g++) begin : g_bf
    viterbi_acs_butterfly #(.DST(g)) u_bf (
      .pm_a   (ipm[2*(g%2)]),
      .pm_b   (ipm[2*(g%2)+1]),
      .r0     (bus.r0),
      .r1     (bus.r1),
      .pm_new (cand[g]),
      .dec    (dec_c[g])
    );
  end

  // The spread after normalisation is bounded, so the 8-bit cast is lossless
  always_comb begin
    new_min = cand[0];
    for (int i = 1; i < NSTATES; i++)
      if (cand[i] < new_min) new_min = cand[i];
    for (int i = 0; i < NSTATES; i++)
      norm[i] = PM_W'(cand[i] - new_min);
    best_c = 2'd0;
    for (int i = NSTATES - 1; i >= 0; i--)
      if (norm[i] == '0) best_c = 2'(i);
  end

  assign last_sym = (cnt == LAST_CNT);

  always_comb begin
    state_nx = state;
    case (state)
      ST_FIRST: if (bus.st && !last_sym) state_nx = ST_RUN;
      ST_RUN:   if (bus.st && last_sym)  state_nx = ST_FIRST;
      default:  state_nx = ST_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FIRST;
      cnt        <= '0;
      dec_q      <= '0;
      best_q     <= '0;
      out_st_q   <= 1'b0;
      out_last_q <= 1'b0;
      for (int i = 0; i < NSTATES; i++) begin
        ipm[i]  <= (i == 0) ? '0 : INIT_V;
        pm_q[i] <= (i == 0) ? '0 : INIT_V;
      end
    end else begin
      state      <= state_nx;
      out_st_q   <= bus.st;
      out_last_q <= bus.st && last_sym;
      if (bus.st) begin
        cnt    <= last_sym ? 8'd0 : cnt + 8'd1;
        dec_q  <= dec_c;
        best_q <= best_c;
        // Frame end reports the computed metrics but restarts from the frame-start set
        for (int i = 0; i < NSTATES; i++) begin
          pm_q[i] <= norm[i];
          ipm[i]  <= last_sym ? ((i == 0) ? '0 : INIT_V) : norm[i];
        end
      end
    end
  end

  assign bus.out_st    = out_st_q;
  assign bus.out_last  = out_last_q;
  assign bus.pm0       = pm_q[0];
  assign bus.pm1       = pm_q[1];
  assign bus.pm2       = pm_q[2];
  assign bus.pm3       = pm_q[3];
  assign bus.dec       = dec_q;
  assign bus.best      = best_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_viterbi_acs.sv
// Randomised and directed bench for viterbi_acs against a transition-table trellis model.
module tb_viterbi_acs;
  import viterbi_pkg::*;

  localparam int INIT = 16;
  localparam int FL   = 4;

  localparam logic [39:0] RST_VEC = {1'b0, 1'b0, 8'd0, 8'd16, 8'd16, 8'd16, 4'd0, 2'd0};
  localparam logic [39:0] S00_VEC = {1'b1, 1'b0, 8'd0, 8'd17, 8'd2, 8'd17, 4'd0, 2'd0};
  localparam logic [39:0] S11_VEC = {1'b1, 1'b0, 8'd2, 8'd17, 8'd0, 8'd17, 4'd0, 2'd2};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  viterbi_acs_if bus ();

  viterbi_acs #(.INIT_PM(INIT), .FRAME_LEN(FL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: path metrics, symbol count, last expected output vector
  int          m_pm [4];
  int          m_cnt;
  logic [39:0] m_out;
  logic [39:0] exp_q [$];

  function automatic logic [39:0] obs();
    return {bus.out_st, bus.out_last, bus.pm0, bus.pm1, bus.pm2, bus.pm3, bus.dec, bus.best};
  endfunction

  function automatic acs_state_e exp_state();
    return (m_cnt == 0) ? ST_FIRST : ST_RUN;
  endfunction

  task automatic model_reset();
    m_pm[0] = 0;
    for (int i = 1; i < 4; i++) m_pm[i] = INIT;
    m_cnt = 0;
    m_out = RST_VEC;
  endtask

  // Walk every (state, input) transition of the encoder and keep the best arrival
  task automatic model_sym(input bit a0, input bit a1);
    int   nw [4];
    bit   d  [4];
    int   nrm[4];
    int   mn, bst;
    bit   last;
    for (int n = 0; n < 4; n++) begin nw[n] = -1; d[n] = 0; end
    for (int p = 0; p < 4; p++) begin
      for (int u = 0; u < 2; u++) begin
        int b1, b0, c0, c1, n, bm, c;
        b1 = p / 2;
        b0 = p % 2;
        c0 = u ^ b1 ^ b0;
        c1 = u ^ b0;
        n  = u * 2 + b1;
        bm = ((a0 != c0[0]) ? 1 : 0) + ((a1 != c1[0]) ? 1 : 0);
        c  = m_pm[p] + bm;
        if (nw[n] < 0 || c < nw[n]) begin
          nw[n] = c;
          d[n]  = (p % 2 == 1);
        end
      end
    end
    mn = nw[0];
    for (int n = 1; n < 4; n++) if (nw[n] < mn) mn = nw[n];
    bst = -1;
    for (int n = 0; n < 4; n++) begin
      nrm[n] = nw[n] - mn;
      if (nrm[n] == 0 && bst < 0) bst = n;
    end
    last  = (m_cnt == FL - 1);
    m_out = {1'b1, last, 8'(nrm[0]), 8'(nrm[1]), 8'(nrm[2]), 8'(nrm[3]),
             d[3], d[2], d[1], d[0], 2'(bst)};
    if (last) begin
      m_pm[0] = 0;
      for (int i = 1; i < 4; i++) m_pm[i] = INIT;
      m_cnt = 0;
    end else begin
      for (int i = 0; i < 4; i++) m_pm[i] = nrm[i];
      m_cnt = m_cnt + 1;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with results visible
  task automatic step(input bit v, input bit a0, input bit a1);
    bus.st = v;
    bus.r0 = a0;
    bus.r1 = a1;
    if (v) model_sym(a0, a1);
    else   m_out[39:38] = 2'b00;
    exp_q.push_back(m_out);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    bus.st = 1'b0;
    bus.r0 = 1'b0;
    bus.r1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (obs() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=%h", obs(), RST_VEC);
    end
    n_tests++;
    if (bus.fsm_state !== ST_FIRST) begin
      n_fail++;
      $display("FAIL reset_state got=%0d exp=%0d", bus.fsm_state, ST_FIRST);
    end
  endtask

  task automatic test_sym00();
    do_reset();
    step(1, 0, 0);
    n_tests++;
    if (obs() !== S00_VEC) begin
      n_fail++;
      $display("FAIL sym00 got=%h exp=%h", obs(), S00_VEC);
    end
    step(0, 0, 0);
    n_tests++;
    if (obs() !== {2'b00, S00_VEC[37:0]}) begin
      n_fail++;
      $display("FAIL sym00_hold got=%h exp=%h", obs(), {2'b00, S00_VEC[37:0]});
    end
  endtask

  task automatic test_sym11();
    do_reset();
    step(1, 1, 1);
    n_tests++;
    if (obs() !== S11_VEC) begin
      n_fail++;
      $display("FAIL sym11 got=%h exp=%h", obs(), S11_VEC);
    end
  endtask

  task automatic test_zero_run();
    logic [39:0] e;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 0);
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL zero_run_model k=%0d got=%h exp=%h", k, obs(), e);
      end
      n_tests++;
      if (bus.out_st !== 1'b1 || bus.pm0 !== 8'd0 || bus.best !== 2'd0 ||
          bus.pm1 > INIT + 2 || bus.pm2 > INIT + 2 || bus.pm3 > INIT + 2) begin
        n_fail++;
        $display("FAIL zero_run_bounds k=%0d got st=%b pm=%0d,%0d,%0d,%0d best=%0d exp st=1 pm0=0 best=0 pm<=%0d",
                 k, bus.out_st, bus.pm0, bus.pm1, bus.pm2, bus.pm3, bus.best, INIT + 2);
      end
    end
  endtask

  task automatic test_frame();
    logic [39:0] e;
    acs_state_e  es;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1, k == 4, k == 4);
      e = exp_q.pop_front();
      n_tests++;
      if (bus.out_last !== (k == 3) || obs() !== e) begin
        n_fail++;
        $display("FAIL frame_sym k=%0d got=%h last=%b exp=%h last=%b", k, obs(), bus.out_last, e, (k == 3));
      end
      es = (k == 3) ? ST_FIRST : ST_RUN;
      n_tests++;
      if (bus.fsm_state !== es) begin
        n_fail++;
        $display("FAIL frame_state k=%0d got=%0d exp=%0d", k, bus.fsm_state, es);
      end
    end
    n_tests++;
    if (obs() !== S11_VEC) begin
      n_fail++;
      $display("FAIL frame_reload got=%h exp=%h", obs(), S11_VEC);
    end
  endtask

  task automatic test_reset_collision();
    do_reset();
    step(1, 0, 0);
    step(1, 1, 0);
    rst    = 1'b1;
    bus.st = 1'b1;
    bus.r0 = 1'b1;
    bus.r1 = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    bus.st = 1'b0;
    model_reset();
    exp_q.delete();
    n_tests++;
    if (obs() !== RST_VEC || bus.fsm_state !== ST_FIRST) begin
      n_fail++;
      $display("FAIL rst_collision got=%h state=%0d exp=%h state=%0d", obs(), bus.fsm_state, RST_VEC, ST_FIRST);
    end
    step(1, 0, 0);
    n_tests++;
    if (obs() !== S00_VEC) begin
      n_fail++;
      $display("FAIL rst_collision_next got=%h exp=%h", obs(), S00_VEC);
    end
  endtask

  task automatic test_tie();
    logic [39:0] e;
    logic [39:0] hand;
    do_reset();
    step(1, 0, 0);
    void'(exp_q.pop_front());
    step(1, 1, 0);
    e = exp_q.pop_front();
    hand = {1'b1, 1'b0, 8'd0, 8'd1, 8'd0, 8'd3, 4'd0, 2'd0};
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL tie_model got=%h exp=%h", obs(), e);
    end
    n_tests++;
    if (obs() !== hand) begin
      n_fail++;
      $display("FAIL tie_hand got=%h exp=%h", obs(), hand);
    end
  endtask

  task automatic test_random();
    logic [39:0] e;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e || bus.fsm_state !== exp_state()) begin
        n_fail++;
        $display("FAIL random k=%0d got=%h state=%0d exp=%h state=%0d", k, obs(), bus.fsm_state, e, exp_state());
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    bus.st = 1'b0;
    bus.r0 = 1'b0;
    bus.r1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_sym00();
    test_sym11();
    test_zero_run();
    test_frame();
    test_reset_collision();
    test_tie();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
